// File: rtl/phase_stall_control_if.sv
// Phase bus and data-memory handshake between the phase counter, the stall
// controller (slave) and the counter/memory side that drives it (master).
interface phase_stall_control_if;
    logic [3:0] phase;
    logic       memRead;
    logic       memWrite;
    logic       memAck;
    logic       memReq;
    logic       memWe;
    logic       notUpdate;

    modport master (
        output phase,
        output memRead,
        output memWrite,
        output memAck,
        input  memReq,
        input  memWe,
        input  notUpdate
    );

    modport slave (
        input  phase,
        input  memRead,
        input  memWrite,
        input  memAck,
        output memReq,
        output memWe,
        output notUpdate
    );
endinterface

// File: rtl/phase_stall_control.sv
// Stalls the 4-phase counter during the memory phase until data memory acks,
// and flags illegal phase values/sequences seen on the phase bus.
module phase_stall_control #(
    parameter int MEM_PHASE = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    phase_stall_control_if.slave         bus,
    input  logic                         clearError,
    output logic                         phaseError,
    output logic                         timeoutError
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [7:0] waitCount;
    logic       memReqReg;
    logic       memWeReg;
    logic       holdReq;
    logic       timeoutHit;
    logic       hit;
    logic       access;
    logic       lastWait;
    logic [3:0] prevPhase;
    logic       prevHold;
    logic       phaseBad;
    logic [3:0] prevRotated;

    function automatic logic isOneHot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    assign hit         = bus.phase[MEM_PHASE] & isOneHot(bus.phase);
    assign access      = bus.memRead | bus.memWrite;
    assign lastWait    = (waitCount == 8'(TIMEOUT - 1));
    assign prevRotated = {prevPhase[2:0], prevPhase[3]};

    // The hold must already be low during reset, not just after the next edge
    assign bus.notUpdate = holdReq & reset;
    assign bus.memReq    = memReqReg;
    assign bus.memWe     = memWeReg;

    always_comb begin
        nextState  = state;
        holdReq    = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (hit && access) begin
                    holdReq   = 1'b1;
                    nextState = REQ;
                end
            end
            REQ: begin
                if (bus.memAck) begin
                    nextState = IDLE;
                end else if (lastWait) begin
                    nextState  = IDLE;
                    timeoutHit = 1'b1;
                end else begin
                    holdReq = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            memReqReg <= 1'b0;
            memWeReg  <= 1'b0;
            waitCount <= 8'd0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (hit && access) begin
                        memReqReg <= 1'b1;
                        memWeReg  <= bus.memWrite;
                        waitCount <= 8'd0;
                    end
                end
                REQ: begin
                    if (bus.memAck || lastWait) begin
                        memReqReg <= 1'b0;
                        memWeReg  <= 1'b0;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                default: begin
                    memReqReg <= 1'b0;
                    memWeReg  <= 1'b0;
                end
            endcase
        end
    end

    // A zero phase is never illegal; it also blanks the sequence check next cycle
    always_comb begin
        phaseBad = 1'b0;
        if (bus.phase != 4'b0000) begin
            if (!isOneHot(bus.phase)) begin
                phaseBad = 1'b1;
            end else if (prevHold && prevPhase != 4'b0000) begin
                phaseBad = (bus.phase != prevPhase);
            end else if (!prevHold && isOneHot(prevPhase)) begin
                phaseBad = !((bus.phase == prevRotated) ||
                             (bus.phase == prevPhase)   ||
                             (bus.phase == 4'b0001));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prevPhase    <= 4'b0000;
            prevHold     <= 1'b0;
            phaseError   <= 1'b0;
            timeoutError <= 1'b0;
        end else begin
            prevPhase <= bus.phase;
            prevHold  <= bus.notUpdate;
            if (phaseBad) begin
                phaseError <= 1'b1;
            end else if (clearError) begin
                phaseError <= 1'b0;
            end
            if (timeoutHit) begin
                timeoutError <= 1'b1;
            end else if (clearError) begin
                timeoutError <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phase_stall_control.sv
// Directed bench for phase_stall_control: handshake latency, timeout abort,
// asynchronous reset and the phase-sequence checker.
module tb_phase_stall_control;

    logic clock;
    logic reset;
    logic clearError;
    logic phaseError;
    logic timeoutError;
    int   checkCount;
    int   errorCount;

    phase_stall_control_if bus ();

    phase_stall_control #(
        .MEM_PHASE (2),
        .TIMEOUT   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .clearError   (clearError),
        .phaseError   (phaseError),
        .timeoutError (timeoutError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ph, input logic rd, input logic wr, input logic ack);
        bus.phase    = ph;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.memAck   = ack;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        clearError = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) nextCycle();

        // Reset state, including notUpdate forced low while a hit is presented
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("rstReq", 8'(bus.memReq), 8'd0);
        checkOutput("rstWe", 8'(bus.memWe), 8'd0);
        checkOutput("rstHold", 8'(bus.notUpdate), 8'd0);
        checkOutput("rstPerr", 8'(phaseError), 8'd0);
        checkOutput("rstTerr", 8'(timeoutError), 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        reset = 1'b1;

        // Read with ack the cycle after the hit
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("t2HitHold", 8'(bus.notUpdate), 8'd1);
        checkOutput("t2HitReq", 8'(bus.memReq), 8'd0);
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("t2Req", 8'(bus.memReq), 8'd1);
        checkOutput("t2We", 8'(bus.memWe), 8'd0);
        checkOutput("t2AckHold", 8'(bus.notUpdate), 8'd0);
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t2Drop", 8'(bus.memReq), 8'd0);
        checkOutput("t2IdleHold", 8'(bus.notUpdate), 8'd0);
        checkOutput("t2Perr", 8'(phaseError), 8'd0);

        // Read+write, ack on the third REQ cycle; inputs dropped to show no re-sample
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
        #2;
        checkOutput("t3HitHold", 8'(bus.notUpdate), 8'd1);
        for (int i = 0; i < 2; i++) begin
            nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
            #2;
            checkOutput("t3WaitReq", 8'(bus.memReq), 8'd1);
            checkOutput("t3WaitWe", 8'(bus.memWe), 8'd1);
            checkOutput("t3WaitHold", 8'(bus.notUpdate), 8'd1);
        end
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("t3AckReq", 8'(bus.memReq), 8'd1);
        checkOutput("t3AckWe", 8'(bus.memWe), 8'd1);
        checkOutput("t3AckHold", 8'(bus.notUpdate), 8'd0);
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t3DoneReq", 8'(bus.memReq), 8'd0);
        checkOutput("t3DoneWe", 8'(bus.memWe), 8'd0);
        checkOutput("t3Perr", 8'(phaseError), 8'd0);
        checkOutput("t3Terr", 8'(timeoutError), 8'd0);

        // No ack: eight REQ cycles, hold released on the eighth, sticky timeout
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("t4HitHold", 8'(bus.notUpdate), 8'd1);
        for (int k = 1; k <= 8; k++) begin
            nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
            #2;
            checkOutput("t4Req", 8'(bus.memReq), 8'd1);
            checkOutput("t4Hold", 8'(bus.notUpdate), (k < 8) ? 8'd1 : 8'd0);
            checkOutput("t4TerrEarly", 8'(timeoutError), 8'd0);
        end
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t4AbortReq", 8'(bus.memReq), 8'd0);
        checkOutput("t4Terr", 8'(timeoutError), 8'd1);
        checkOutput("t4Perr", 8'(phaseError), 8'd0);
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        clearError = 1'b1;
        #2;
        checkOutput("t4TerrSticky", 8'(timeoutError), 8'd1);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        clearError = 1'b0;
        #2;
        checkOutput("t4TerrClear", 8'(timeoutError), 8'd0);

        // Asynchronous reset three cycles into the wait of a store
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("t1HitHold", 8'(bus.notUpdate), 8'd1);
        for (int k = 0; k < 3; k++) begin
            nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
            #2;
            checkOutput("t1WaitReq", 8'(bus.memReq), 8'd1);
        end
        nextCycle();
        #2;
        checkOutput("t1PreWe", 8'(bus.memWe), 8'd1);
        checkOutput("t1PreHold", 8'(bus.notUpdate), 8'd1);
        reset = 1'b0;
        #1;
        checkOutput("t1AsyncReq", 8'(bus.memReq), 8'd0);
        checkOutput("t1AsyncWe", 8'(bus.memWe), 8'd0);
        checkOutput("t1AsyncHold", 8'(bus.notUpdate), 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        reset = 1'b1;
        #2;
        checkOutput("t1PostReq", 8'(bus.memReq), 8'd0);
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t1IdleAckIgnored", 8'(bus.memReq), 8'd0);
        nextCycle(); applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("t1IdleHit", 8'(bus.notUpdate), 8'd1);
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("t1NewReq", 8'(bus.memReq), 8'd1);
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t1NewDone", 8'(bus.memReq), 8'd0);
        checkOutput("t1Perr", 8'(phaseError), 8'd0);

        // Phase checker: skipped phase, multi-hot, and counter restart
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t5SkipBefore", 8'(phaseError), 8'd0);
        nextCycle(); applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        clearError = 1'b1;
        #2;
        checkOutput("t5Skip", 8'(phaseError), 8'd1);
        nextCycle(); applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
        clearError = 1'b0;
        #2;
        checkOutput("t5Cleared", 8'(phaseError), 8'd0);
        nextCycle(); applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        clearError = 1'b1;
        #2;
        checkOutput("t5MultiHot", 8'(phaseError), 8'd1);
        nextCycle(); applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        clearError = 1'b0;
        #2;
        checkOutput("t5Cleared2", 8'(phaseError), 8'd0);
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        nextCycle(); applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t5Restart", 8'(phaseError), 8'd0);

        // Phase moves while held; handshake still completes
        nextCycle(); applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("t6HitHold", 8'(bus.notUpdate), 8'd1);
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t6Req", 8'(bus.memReq), 8'd1);
        checkOutput("t6Hold", 8'(bus.notUpdate), 8'd1);
        checkOutput("t6PerrBefore", 8'(phaseError), 8'd0);
        nextCycle(); applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("t6Perr", 8'(phaseError), 8'd1);
        checkOutput("t6ReqKept", 8'(bus.memReq), 8'd1);
        checkOutput("t6AckHold", 8'(bus.notUpdate), 8'd0);
        nextCycle(); applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        clearError = 1'b1;
        #2;
        checkOutput("t6Done", 8'(bus.memReq), 8'd0);
        checkOutput("t6PerrSticky", 8'(phaseError), 8'd1);
        nextCycle();
        clearError = 1'b0;
        #2;
        checkOutput("t6PerrClear", 8'(phaseError), 8'd0);
        checkOutput("t6Terr", 8'(timeoutError), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
